arbiter_sched: RTL and testbench
================================

ARBITER_SCHED -- requirements
Module: arbiter_sched

Interface
REQ-001 Parameter NUM_PORTS, default 16, number of requesting write ports (2..32).
REQ-002 Parameter PRIO_W, default 3, priority field width per port.
REQ-003 Parameter SEL_W, default $clog2(NUM_PORTS), width of select.
REQ-004 Parameter MAX_PKT, default 1024, transfer watchdog limit in cycles; 0 disables the watchdog.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 mode  input  2  00 strict priority, 01 weighted round robin, 10 plain round robin, 11 treated as 10.
REQ-008 sop  input  NUM_PORTS  per-port request level; held by the port until it is granted.
REQ-009 eop  input  NUM_PORTS  per-port end-of-packet strobe, one cycle.
REQ-010 priority_in  input  NUM_PORTS*PRIO_W  port i priority at bits [(i+1)*PRIO_W-1 : i*PRIO_W]; larger value = higher priority.
REQ-011 select  output  SEL_W  index of the granted port.
REQ-012 grant  output  NUM_PORTS  one-hot grant, all zero when idle.
REQ-013 transfering  output  1  high while a granted packet is in flight.
REQ-014 timeout  output  1  one-cycle pulse when the watchdog force-releases a grant.

Function
REQ-015 The FSM SHALL have two states: IDLE and XFER.
REQ-016 In IDLE, with at least one eligible request, the block SHALL register the winner; select, grant and transfering SHALL update on the next edge and the FSM SHALL enter XFER.
REQ-017 Arbitration latency SHALL be one cycle, measured from the sop sample in IDLE to transfering high.
REQ-018 In XFER, select and grant SHALL stay constant; sop changes on any port SHALL be ignored.
REQ-019 In XFER, eop[select]=1 SHALL return the FSM to IDLE; transfering and grant SHALL clear on that edge.
REQ-020 eop on non-granted ports SHALL be ignored in all states.
REQ-021 eop[select] in the first XFER cycle SHALL be honoured as a one-cycle packet.
REQ-022 After release, the FSM SHALL spend exactly one IDLE cycle before the next grant, giving a minimum inter-packet gap of 1 cycle.
REQ-023 select SHALL hold its last value in IDLE.
REQ-024 mode SHALL be sampled only in IDLE; a change during XFER SHALL take effect at the next arbitration.
REQ-025 Strict priority: among requesting ports, the highest priority_in SHALL win; ties SHALL be resolved round-robin starting at rr_ptr.
REQ-026 Round robin: the first requesting port at or after rr_ptr, with wrap-around from NUM_PORTS-1 to 0, SHALL win.
REQ-027 In SP and RR modes, rr_ptr SHALL become (winner+1) mod NUM_PORTS on each grant.
REQ-028 WRR: each port SHALL own a credit counter of PRIO_W+1 bits.
REQ-029 WRR eligibility SHALL be sop[i]=1 and credit[i]>0; the winner is the first eligible port at or after rr_ptr.
REQ-030 WRR grant SHALL decrement the winner's credit by 1.
REQ-031 In WRR, rr_ptr SHALL stay on the winner while its remaining credit is >0, otherwise it advances to winner+1.
REQ-032 In WRR, when requests exist but no requesting port has credit, all credits SHALL reload to priority_in[i]+1 and the block SHALL arbitrate with the reloaded values in the same cycle, adding no extra latency.
REQ-033 Watchdog: when MAX_PKT>0, a cycle counter SHALL run in XFER; reaching MAX_PKT without eop[select] SHALL release the grant exactly as eop would and pulse timeout for one cycle.
REQ-034 With no request in IDLE, the FSM SHALL stay in IDLE and every output except select SHALL be 0.

Reset
REQ-035 While rst=0, and immediately on its assertion with no clock edge needed, the block SHALL force: FSM=IDLE, select=0, grant=0, transfering=0, timeout=0, rr_ptr=0, all credits=0, watchdog counter=0.
REQ-036 Reset asserted mid-transfer SHALL abort the packet with no timeout pulse; the first arbitration after reset in WRR SHALL reload credits per REQ-032.

Verification
REQ-037 SP: mode=00, sop=16'h0111, priorities p0=2, p4=5, p8=5 -> select=4 one cycle later; after eop[4] and sop[4] low -> select=8.
REQ-038 RR wrap: mode=10, sop on ports 3 and 15 held, rr_ptr=15 -> grant order 15, 3, 15, each released by eop, with 1 idle cycle between grants.
REQ-039 WRR: mode=01, ports 0 and 1 requesting continuously, p0=2, p1=0, one-cycle packets -> grant sequence 0,0,0,1 repeating.
REQ-040 Watchdog: MAX_PKT=8, port 5 granted, no eop -> transfering falls 8 cycles after the grant with timeout pulsed once; eop[7] during the transfer has no effect.
REQ-041 Reset: rst low 3 cycles into an XFER -> all outputs 0 without a clock edge; after rst goes high with sop held -> a new grant 1 cycle later.

Source files
------------

// File: rtl/arbiter_sched.sv
// Packet-level arbiter for NUM_PORTS write ports: strict priority, weighted or plain
// round robin, holding each grant until eop from the granted port or a watchdog release.
module arbiter_sched #(
    parameter int NUM_PORTS = 16,
    parameter int PRIO_W    = 3,
    parameter int SEL_W     = $clog2(NUM_PORTS),
    parameter int MAX_PKT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic [NUM_PORTS-1:0]        sop,
    input  logic [NUM_PORTS-1:0]        eop,
    input  logic [NUM_PORTS*PRIO_W-1:0] priority_in,
    output logic [SEL_W-1:0]            select,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        transfering,
    output logic                        timeout
);

    localparam int CRED_W = PRIO_W + 1;
    localparam int WD_W   = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((MAX_PKT > 0) ? MAX_PKT - 1 : 0);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       select_q, select_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic                   xfer_q, xfer_d;
    logic                   timeout_q, timeout_d;
    logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0]      credit_q [NUM_PORTS];
    logic [CRED_W-1:0]      credit_d [NUM_PORTS];
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;

    logic [PRIO_W-1:0]      prio [NUM_PORTS];
    logic [PRIO_W-1:0]      max_prio;
    logic [NUM_PORTS-1:0]   sp_req, wrr_has_cred, wrr_req;
    logic                   wrr_reload;
    logic [CRED_W-1:0]      cred_eff [NUM_PORTS];
    logic [SEL_W-1:0]       winner;
    logic [CRED_W-1:0]      win_left;
    logic                   wd_fire;
    logic                   eop_sel;

    // First set bit of req at or after ptr, wrapping from NUM_PORTS-1 to 0.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [SEL_W-1:0]     ptr);
        logic             found;
        logic [SEL_W-1:0] cand;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = SEL_W'((int'(ptr) + i) % NUM_PORTS);
            if (!found && req[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    endfunction

    function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
        next_port = (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        max_prio = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            prio[i] = priority_in[i*PRIO_W +: PRIO_W];
            if (sop[i] && prio[i] > max_prio) max_prio = prio[i];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            sp_req[i]       = sop[i] && (prio[i] == max_prio);
            wrr_has_cred[i] = sop[i] && (credit_q[i] != '0);
        end
        // An exhausted WRR round reloads and arbitrates on the fresh credits in the same cycle.
        wrr_reload = (sop != '0) && (wrr_has_cred == '0);
        for (int i = 0; i < NUM_PORTS; i++) begin
            cred_eff[i] = wrr_reload ? ({1'b0, prio[i]} + CRED_W'(1)) : credit_q[i];
        end
        wrr_req = wrr_reload ? sop : wrr_has_cred;
        case (mode)
            2'b00:   winner = rr_pick(sp_req, rr_ptr_q);
            2'b01:   winner = rr_pick(wrr_req, rr_ptr_q);
            default: winner = rr_pick(sop, rr_ptr_q);
        endcase
        win_left = cred_eff[winner] - CRED_W'(1);
        wd_fire  = (MAX_PKT > 0) && (wd_cnt_q == WD_LAST);
        eop_sel  = eop[select_q];
    end

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        grant_d   = grant_q;
        xfer_d    = xfer_q;
        timeout_d = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        credit_d  = credit_q;
        wd_cnt_d  = wd_cnt_q;
        case (state_q)
            IDLE: begin
                if (sop != '0) begin
                    state_d  = XFER;
                    select_d = winner;
                    grant_d  = NUM_PORTS'(1) << winner;
                    xfer_d   = 1'b1;
                    wd_cnt_d = '0;
                    if (mode == 2'b01) begin
                        credit_d         = cred_eff;
                        credit_d[winner] = win_left;
                        rr_ptr_d         = (win_left != '0) ? winner : next_port(winner);
                    end else begin
                        rr_ptr_d = next_port(winner);
                    end
                end
            end
            XFER: begin
                if (eop_sel || wd_fire) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    xfer_d    = 1'b0;
                    timeout_d = !eop_sel;
                end else if (MAX_PKT > 0) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            select_q  <= '0;
            grant_q   <= '0;
            xfer_q    <= 1'b0;
            timeout_q <= 1'b0;
            rr_ptr_q  <= '0;
            credit_q  <= '{default: '0};
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            grant_q   <= grant_d;
            xfer_q    <= xfer_d;
            timeout_q <= timeout_d;
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign select      = select_q;
    assign grant       = grant_q;
    assign transfering = xfer_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_arbiter_sched.sv
// Scoreboard bench for arbiter_sched: directed scenarios push the expected winner,
// a negedge monitor pops it whenever a new grant appears.
module tb_arbiter_sched;

    localparam int NP = 16;
    localparam int PW = 3;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [NP-1:0]     sop = '0;
    logic [NP-1:0]     eop = '0;
    logic [NP*PW-1:0]  prio_bus = '0;
    logic [SW-1:0]     select;
    logic [NP-1:0]     grant;
    logic              transfering;
    logic              timeout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic prev_xfer = 1'b0;

    arbiter_sched #(.NUM_PORTS(NP), .PRIO_W(PW), .MAX_PKT(8)) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .sop(sop),
        .eop(eop),
        .priority_in(prio_bus),
        .select(select),
        .grant(grant),
        .transfering(transfering),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int p, input int v);
        prio_bus[p*PW +: PW] = PW'(v);
    endtask

    // Arbitration cycle: the winner must be presented right after one edge.
    task automatic arb(input int p);
        exp_q.push_back(p);
        tick();
        chk("arb_latency", 32'(transfering), 1);
    endtask

    // Hold the packet len cycles in total, end it with eop, then check the idle gap cycle.
    task automatic serve(input int p, input int len);
        for (int k = 1; k < len; k++) tick();
        eop[p] = 1'b1;
        tick();
        eop = '0;
        chk("release_xfer", 32'(transfering), 0);
        chk("release_grant", 32'(grant), 0);
        chk("hold_select", 32'(select), p);
    endtask

    initial begin
        int e;
        logic [NP-1:0] eg;
        forever begin
            @(negedge clk);
            if (transfering && !prev_xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: select %0d, expected no grant", select);
                end else begin
                    e = exp_q.pop_front();
                    eg = '0;
                    eg[e] = 1'b1;
                    if (32'(select) != e || grant !== eg) begin
                        errors++;
                        $display("FAIL grant_order: select %0d grant %0h, expected select %0d grant %0h",
                                 select, grant, e, eg);
                    end
                end
            end
            checks++;
            eg = '0;
            if (transfering) eg[select] = 1'b1;
            if (grant !== eg) begin
                errors++;
                $display("FAIL grant_consistency: grant %0h, expected %0h", grant, eg);
            end
            prev_xfer = transfering;
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int wseq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_select", 32'(select), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_xfer", 32'(transfering), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_xfer", 32'(transfering), 0);
        chk("idle_grant", 32'(grant), 0);

        // Strict priority: p4 and p8 tie at 5, round robin from 0 picks 4 first.
        mode = 2'b00;
        set_prio(0, 2); set_prio(4, 5); set_prio(8, 5);
        sop = 16'h0111;
        arb(4);
        sop = 16'h0101;
        tick();
        eop[0] = 1'b1;
        tick();
        eop = '0;
        chk("sp_hold_select", 32'(select), 4);
        chk("sp_foreign_eop", 32'(transfering), 1);
        serve(4, 1);
        arb(8);
        sop = 16'h0001;
        serve(8, 1);
        arb(0);
        sop = '0;
        serve(0, 2);

        // Round robin wrap: park rr_ptr at 15 via port 14.
        mode = 2'b10;
        sop = 16'h4000;
        arb(14);
        sop = 16'h8008;
        serve(14, 1);
        arb(15);
        serve(15, 1);
        arb(3);
        serve(3, 1);
        arb(15);
        sop = '0;
        serve(15, 1);
        tick();
        chk("rr_no_req_idle", 32'(transfering), 0);

        // Weighted round robin: p0=2 gives three grants per port-1 grant.
        prio_bus = '0;
        set_prio(0, 2);
        mode = 2'b01;
        sop = 16'h0003;
        for (int n = 0; n < 8; n++) begin
            arb(wseq[n]);
            if (n == 7) sop = '0;
            serve(wseq[n], 1);
        end

        // Watchdog on port 5, stray eop on port 7 in the middle.
        mode = 2'b10;
        sop = 16'h0020;
        arb(5);
        sop = '0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) eop[7] = 1'b1;
            tick();
            eop = '0;
            if (k < 8) begin
                chk("wd_xfer_held", 32'(transfering), 1);
                chk("wd_no_timeout", 32'(timeout), 0);
            end else if (k == 8) begin
                chk("wd_release", 32'(transfering), 0);
                chk("wd_timeout_pulse", 32'(timeout), 1);
                chk("wd_grant_clear", 32'(grant), 0);
            end else begin
                chk("wd_timeout_once", 32'(timeout), 0);
                chk("wd_stay_idle", 32'(transfering), 0);
            end
        end

        // Asynchronous reset three cycles into a WRR transfer.
        mode = 2'b01;
        sop = 16'h0004;
        arb(2);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_select", 32'(select), 0);
        chk("arst_grant", 32'(grant), 0);
        chk("arst_xfer", 32'(transfering), 0);
        chk("arst_timeout", 32'(timeout), 0);
        tick();
        tick();
        chk("arst_held", 32'(transfering), 0);
        rst = 1'b1;
        arb(2);
        sop = '0;
        serve(2, 1);

        // Mode switched during XFER governs the following arbitration.
        set_prio(6, 7);
        mode = 2'b10;
        sop = 16'h0042;
        arb(6);
        mode = 2'b00;
        tick();
        serve(6, 1);
        arb(6);
        sop = '0;
        serve(6, 1);
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
